// File: rtl/cat_game_ctrl.sv
// cat_game_ctrl: CatTrap game-state engine for an 8x8 board.
// Holds the wall map, the cat position and the player/cat turn state machine.
// The player places walls with one-hot Row/Col selects. After each accepted wall
// the cat checks whether it sits on the border (escape). If it does not, the cat
// tries its neighbours in the order up, right, down, left, one per cycle, and moves
// to the first free one. If all four neighbours are walled, the cat is trapped.
module cat_game_ctrl #(
  parameter logic [2:0]  CAT_START_ROW = 3'd3,
  parameter logic [2:0]  CAT_START_COL = 3'd3,
  parameter logic [63:0] INIT_WALLS    = 64'h0
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [7:0]  Row,
  input  logic [7:0]  Col,
  input  logic        start_pulse,
  input  logic        place_pulse,
  output logic [63:0] wall_map,
  output logic [2:0]  cat_row,
  output logic [2:0]  cat_col,
  output logic [1:0]  status,
  output logic [7:0]  move_count,
  output logic        bad_sel,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    PLAYER,
    CAT_CHECK,
    CAT_SCAN,
    WIN,
    LOSE
  } state_t;

  localparam logic [1:0] STATUS_IDLE    = 2'b00;
  localparam logic [1:0] STATUS_PLAYING = 2'b01;
  localparam logic [1:0] STATUS_WIN     = 2'b10;
  localparam logic [1:0] STATUS_LOSE    = 2'b11;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  state_t     state;
  logic [1:0] scan_idx;

  logic [2:0] sel_row;
  logic [2:0] sel_col;
  logic [5:0] target_idx;
  logic       sel_onehot;
  logic       target_walled;
  logic       target_is_cat;
  logic       place_ok;

  logic [2:0] nbr_row;
  logic [2:0] nbr_col;
  logic       nbr_walled;
  logic       cat_on_edge;

  // Convert a one-hot select into a binary index. The result is only used
  // after the select has been confirmed to be one-hot.
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) idx = k[2:0];
    end
    return idx;
  endfunction

  // Decode the player's selection and decide whether a wall may go there.
  always_comb begin
    sel_row       = onehot_idx(Row);
    sel_col       = onehot_idx(Col);
    target_idx    = {sel_row, sel_col};
    sel_onehot    = $onehot(Row) && $onehot(Col);
    target_walled = wall_map[target_idx];
    target_is_cat = (sel_row == cat_row) && (sel_col == cat_col);
    place_ok      = sel_onehot && !target_walled && !target_is_cat;
  end

  // Compute the neighbour under test during the scan. The cat is always
  // interior here, so the +/-1 arithmetic cannot wrap.
  always_comb begin
    nbr_row = cat_row;
    nbr_col = cat_col;
    case (scan_idx)
      DIR_UP:    nbr_row = cat_row - 3'd1;
      DIR_RIGHT: nbr_col = cat_col + 3'd1;
      DIR_DOWN:  nbr_row = cat_row + 3'd1;
      DIR_LEFT:  nbr_col = cat_col - 3'd1;
      default:   nbr_row = cat_row;
    endcase
    nbr_walled  = wall_map[{nbr_row, nbr_col}];
    cat_on_edge = (cat_row == 3'd0) || (cat_row == 3'd7) ||
                  (cat_col == 3'd0) || (cat_col == 3'd7);
  end

  // Turn state machine. Every output is a register updated here. A start
  // request reloads the board from any state and overrides a placement
  // arriving in the same cycle.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      scan_idx   <= 2'd0;
      wall_map   <= INIT_WALLS;
      cat_row    <= CAT_START_ROW;
      cat_col    <= CAT_START_COL;
      status     <= STATUS_IDLE;
      move_count <= 8'd0;
      bad_sel    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bad_sel <= 1'b0;
      if (start_pulse) begin
        state      <= PLAYER;
        scan_idx   <= 2'd0;
        wall_map   <= INIT_WALLS;
        cat_row    <= CAT_START_ROW;
        cat_col    <= CAT_START_COL;
        status     <= STATUS_PLAYING;
        move_count <= 8'd0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          PLAYER: begin
            if (place_pulse) begin
              if (place_ok) begin
                wall_map[target_idx] <= 1'b1;
                if (move_count != 8'd255) move_count <= move_count + 8'd1;
                state <= CAT_CHECK;
                busy  <= 1'b1;
              end else begin
                bad_sel <= 1'b1;
              end
            end
          end
          CAT_CHECK: begin
            if (cat_on_edge) begin
              state  <= LOSE;
              status <= STATUS_LOSE;
              busy   <= 1'b0;
            end else begin
              state    <= CAT_SCAN;
              scan_idx <= 2'd0;
            end
          end
          CAT_SCAN: begin
            if (!nbr_walled) begin
              cat_row <= nbr_row;
              cat_col <= nbr_col;
              state   <= PLAYER;
              busy    <= 1'b0;
            end else if (scan_idx == DIR_LEFT) begin
              state  <= WIN;
              status <= STATUS_WIN;
              busy   <= 1'b0;
            end else begin
              scan_idx <= scan_idx + 2'd1;
            end
          end
          WIN: begin
            state <= WIN;
          end
          LOSE: begin
            state <= LOSE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
